// File: rtl/lnrv_icb2axi_mots.sv
// ICB to AXI4 single-beat bridge with multiple outstanding transactions and in-order responses.
// Optional one-entry response register enabled by defining LNRV_ICB2AXI_RSP_BUF_EN.
module lnrv_icb2axi_mots #(
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_OTS_COUNT  = 4,
  parameter logic [3:0]  P_AXI_ID     = 4'd0
) (
  input  logic                      clk,
  input  logic                      reset_n,

  input  logic                      icb_cmd_vld,
  output logic                      icb_cmd_rdy,
  input  logic                      icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]   icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]   icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] icb_cmd_wstrb,
  input  logic [2:0]                icb_cmd_size,

  output logic                      icb_rsp_vld,
  input  logic                      icb_rsp_rdy,
  output logic                      icb_rsp_err,
  output logic [P_DATA_WIDTH-1:0]   icb_rsp_rdata,

  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [P_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [3:0]                axi_awid,
  output logic [7:0]                axi_awlen,
  output logic [2:0]                axi_awsize,
  output logic [1:0]                axi_awburst,
  output logic [3:0]                axi_awcache,
  output logic [2:0]                axi_awprot,
  output logic                      axi_awlock,

  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic [P_DATA_WIDTH-1:0]   axi_wdata,
  output logic [P_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                      axi_wlast,

  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  input  logic [1:0]                axi_bresp,
  input  logic [3:0]                axi_bid,

  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [P_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                axi_arid,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic [3:0]                axi_arcache,
  output logic [2:0]                axi_arprot,
  output logic                      axi_arlock,

  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [P_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  input  logic [3:0]                axi_rid
);

  localparam int unsigned PTR_W = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
  localparam int unsigned CNT_W = $clog2(P_OTS_COUNT) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(P_OTS_COUNT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(P_OTS_COUNT - 1);

  // Ordering FIFO: one type bit per issued transaction (1 = write)
  logic [P_OTS_COUNT-1:0] type_q, type_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;

  logic full, empty, head_type;
  logic cmd_rd, cmd_wr;
  logic ar_hs, aw_hs, w_hs;
  logic aw_ok, w_ok;
  logic rd_acc, wr_acc, push, pop;
  logic head_vld, head_err;
  logic [P_DATA_WIDTH-1:0] head_data;
  logic rsp_path_rdy;
  logic unused_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign head_type = type_q[rd_ptr_q];

  // Command valids are gated by reset so nothing escapes while reset_n is low
  assign cmd_rd = reset_n & icb_cmd_vld & ~icb_cmd_write & ~full;
  assign cmd_wr = reset_n & icb_cmd_vld &  icb_cmd_write & ~full;

  assign axi_arvalid = cmd_rd;
  assign axi_awvalid = cmd_wr & ~aw_done_q;
  assign axi_wvalid  = cmd_wr & ~w_done_q;

  assign ar_hs = axi_arvalid & axi_arready;
  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid  & axi_wready;

  assign aw_ok  = aw_done_q | aw_hs;
  assign w_ok   = w_done_q  | w_hs;
  assign rd_acc = ar_hs;
  assign wr_acc = cmd_wr & aw_ok & w_ok;
  assign push   = rd_acc | wr_acc;

  assign icb_cmd_rdy = push;

  // Fixed single-beat incrementing attributes; address and data pass straight through
  assign axi_awaddr  = icb_cmd_addr;
  assign axi_awid    = P_AXI_ID;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = icb_cmd_size;
  assign axi_awburst = 2'b01;
  assign axi_awcache = 4'd0;
  assign axi_awprot  = 3'd0;
  assign axi_awlock  = 1'b0;

  assign axi_wdata   = icb_cmd_wdata;
  assign axi_wstrb   = icb_cmd_wstrb;
  assign axi_wlast   = axi_wvalid;

  assign axi_araddr  = icb_cmd_addr;
  assign axi_arid    = P_AXI_ID;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = icb_cmd_size;
  assign axi_arburst = 2'b01;
  assign axi_arcache = 4'd0;
  assign axi_arprot  = 3'd0;
  assign axi_arlock  = 1'b0;

  // Only the channel matching the oldest outstanding transaction may hand over a response
  assign axi_rready = ~empty & ~head_type & rsp_path_rdy;
  assign axi_bready = ~empty &  head_type & rsp_path_rdy;

  assign head_vld  = ~empty & (head_type ? axi_bvalid : axi_rvalid);
  assign head_err  = head_type ? axi_bresp[1] : axi_rresp[1];
  assign head_data = head_type ? '0 : axi_rdata;
  assign pop       = head_vld & rsp_path_rdy;

  assign unused_ok = ^{axi_bid, axi_rid, axi_rlast, axi_bresp[0], axi_rresp[0]};

  // Next-state for ordering FIFO and write-channel progress flags
  always_comb begin
    type_d    = type_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    if (push) begin
      type_d[wr_ptr_q] = icb_cmd_write;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (wr_acc) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      type_q    <= type_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef LNRV_ICB2AXI_RSP_BUF_EN
  // One-entry response register; refilled in the same cycle it drains
  logic                    buf_vld_q, buf_vld_d;
  logic                    buf_err_q, buf_err_d;
  logic [P_DATA_WIDTH-1:0] buf_data_q, buf_data_d;

  assign rsp_path_rdy = ~buf_vld_q | icb_rsp_rdy;

  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_err_d  = buf_err_q;
    buf_data_d = buf_data_q;
    if (pop) begin
      buf_vld_d  = 1'b1;
      buf_err_d  = head_err;
      buf_data_d = head_data;
    end else if (icb_rsp_rdy) begin
      buf_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld_q  <= 1'b0;
      buf_err_q  <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_err_q  <= buf_err_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign icb_rsp_vld   = buf_vld_q;
  assign icb_rsp_err   = buf_err_q;
  assign icb_rsp_rdata = buf_data_q;
`else
  assign rsp_path_rdy  = icb_rsp_rdy;
  assign icb_rsp_vld   = head_vld;
  assign icb_rsp_err   = head_err;
  assign icb_rsp_rdata = head_data;
`endif

endmodule

// File: tb/tb_lnrv_icb2axi_mots.sv
// Self-checking bench for lnrv_icb2axi_mots: directed scenarios plus a randomized
// run checked against an in-order transaction model with a reactive AXI slave.
module tb_lnrv_icb2axi_mots;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int OTS = 4;

  logic          clk, reset_n;
  logic          icb_cmd_vld, icb_cmd_rdy, icb_cmd_write;
  logic [AW-1:0] icb_cmd_addr;
  logic [DW-1:0] icb_cmd_wdata;
  logic [SW-1:0] icb_cmd_wstrb;
  logic [2:0]    icb_cmd_size;
  logic          icb_rsp_vld, icb_rsp_rdy, icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;
  logic          axi_awvalid, axi_awready, axi_awlock;
  logic [AW-1:0] axi_awaddr;
  logic [3:0]    axi_awid, axi_awcache;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize, axi_awprot;
  logic [1:0]    axi_awburst;
  logic          axi_wvalid, axi_wready, axi_wlast;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_bvalid, axi_bready;
  logic [1:0]    axi_bresp;
  logic [3:0]    axi_bid;
  logic          axi_arvalid, axi_arready, axi_arlock;
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_arid, axi_arcache;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize, axi_arprot;
  logic [1:0]    axi_arburst;
  logic          axi_rvalid, axi_rready, axi_rlast;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic [3:0]    axi_rid;

  int errors = 0;
  int checks = 0;
  logic [32:0] rsp_log[$];
  int rsp_rd = 0;
  int ar_cnt = 0;

  lnrv_icb2axi_mots #(
    .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_OTS_COUNT(OTS), .P_AXI_ID(4'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy), .icb_cmd_write(icb_cmd_write),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wstrb(icb_cmd_wstrb),
    .icb_cmd_size(icb_cmd_size),
    .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awlock(axi_awlock),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arlock(axi_arlock),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: records ICB responses and counts AR handshakes late in each low phase
  always @(negedge clk) begin
    #3;
    if (reset_n && icb_rsp_vld && icb_rsp_rdy) rsp_log.push_back({icb_rsp_err, icb_rsp_rdata});
    if (reset_n && axi_arvalid && axi_arready) ar_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output bit ok);
    ok = 0;
    @(negedge clk);
    icb_cmd_vld = 1'b1; icb_cmd_write = wr; icb_cmd_addr = addr;
    icb_cmd_wdata = data; icb_cmd_wstrb = 4'hF; icb_cmd_size = 3'd2;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (icb_cmd_rdy) ok = 1;
      @(negedge clk);
    end
    icb_cmd_vld = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp, output bit ok);
    ok = 0;
    @(negedge clk);
    axi_bvalid = 1'b1; axi_bresp = resp;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (axi_bready) ok = 1;
      @(negedge clk);
    end
    axi_bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] data, input logic [1:0] resp, output bit ok);
    ok = 0;
    @(negedge clk);
    axi_rvalid = 1'b1; axi_rdata = data; axi_rresp = resp; axi_rlast = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (axi_rready) ok = 1;
      @(negedge clk);
    end
    axi_rvalid = 1'b0;
  endtask

  task automatic get_rsp(output bit got, output logic [32:0] v);
    got = 0; v = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rsp_rd < rsp_log.size()) begin
        v = rsp_log[rsp_rd]; rsp_rd++; got = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b0; axi_arready = 1'b1;
    axi_bvalid = 1'b1; axi_rvalid = 1'b1; icb_rsp_rdy = 1'b1;
    #1;
    checks++; if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%b exp=0", axi_arvalid); end
    checks++; if (icb_cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy got=%b exp=0", icb_cmd_rdy); end
    checks++; if ({axi_bready, axi_rready, icb_rsp_vld} !== 3'b000) begin errors++;
      $display("FAIL rst_rsp_side got=%b exp=000", {axi_bready, axi_rready, icb_rsp_vld}); end
    icb_cmd_write = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
    #1;
    checks++; if ({axi_awvalid, axi_wvalid, icb_cmd_rdy} !== 3'b000) begin errors++;
      $display("FAIL rst_write_side got=%b exp=000", {axi_awvalid, axi_wvalid, icb_cmd_rdy}); end
    @(negedge clk);
    icb_cmd_vld = 1'b0; axi_bvalid = 1'b0; axi_rvalid = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    bit ok, got;
    logic [32:0] v;
    @(negedge clk);
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b0; icb_cmd_addr = 32'h100; icb_cmd_size = 3'd2;
    axi_arready = 1'b1; icb_rsp_rdy = 1'b1;
    #1;
    checks++; if (axi_arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid got=%b exp=1", axi_arvalid); end
    checks++; if (axi_araddr !== 32'h100) begin errors++; $display("FAIL rd_araddr got=%h exp=100", axi_araddr); end
    checks++; if ({axi_arlen, axi_arburst, axi_arsize, axi_arid} !== {8'd0, 2'b01, 3'd2, 4'd0}) begin errors++;
      $display("FAIL rd_attrs got=%h/%b/%0d/%0d exp=0/01/2/0", axi_arlen, axi_arburst, axi_arsize, axi_arid); end
    checks++; if ({axi_arcache, axi_arprot, axi_arlock} !== 8'd0) begin errors++;
      $display("FAIL rd_cache_prot got=%h exp=0", {axi_arcache, axi_arprot, axi_arlock}); end
    checks++; if (icb_cmd_rdy !== 1'b1) begin errors++; $display("FAIL rd_cmd_rdy got=%b exp=1", icb_cmd_rdy); end
    @(negedge clk);
    icb_cmd_vld = 1'b0; axi_arready = 1'b0;
    send_r(32'hDEADBEEF, 2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_r_handshake got=none exp=handshake"); end
    get_rsp(got, v);
    checks++; if (!got || v !== {1'b0, 32'hDEADBEEF}) begin errors++;
      $display("FAIL rd_rsp got=%0b/%h exp=0/deadbeef", got, v); end
  endtask

  task automatic test_write_aw_stall();
    bit ok, got;
    logic [32:0] v;
    @(negedge clk);
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b1; icb_cmd_addr = 32'h200;
    icb_cmd_wdata = 32'h12345678; icb_cmd_wstrb = 4'hA; icb_cmd_size = 3'd2;
    axi_awready = 1'b0; axi_wready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) axi_awready = 1'b1;
      #1;
      checks++; if (axi_wvalid !== (c == 0)) begin errors++; $display("FAIL wr_wvalid_c%0d got=%b exp=%b", c, axi_wvalid, c == 0); end
      checks++; if (axi_awvalid !== 1'b1) begin errors++; $display("FAIL wr_awvalid_c%0d got=%b exp=1", c, axi_awvalid); end
      checks++; if (icb_cmd_rdy !== (c == 3)) begin errors++; $display("FAIL wr_cmd_rdy_c%0d got=%b exp=%b", c, icb_cmd_rdy, c == 3); end
      if (c == 0) begin
        checks++; if ({axi_wdata, axi_wstrb, axi_wlast} !== {32'h12345678, 4'hA, 1'b1}) begin errors++;
          $display("FAIL wr_wbeat got=%h/%h/%b exp=12345678/a/1", axi_wdata, axi_wstrb, axi_wlast); end
      end
      if (c == 3) begin
        checks++; if ({axi_awaddr, axi_awlen, axi_awburst} !== {32'h200, 8'd0, 2'b01}) begin errors++;
          $display("FAIL wr_aw got=%h/%h/%b exp=200/0/01", axi_awaddr, axi_awlen, axi_awburst); end
      end
      @(negedge clk);
    end
    icb_cmd_vld = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    send_b(2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_b_handshake got=none exp=handshake"); end
    get_rsp(got, v);
    checks++; if (!got || v !== 33'd0) begin errors++; $display("FAIL wr_rsp got=%0b/%h exp=0/0", got, v); end
  endtask

  task automatic test_ots_full();
    bit ok, got;
    logic [32:0] v;
    logic [31:0] exp_d[5];
    int base;
    base = ar_cnt;
    axi_arready = 1'b1; icb_rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h400 + 32'(i * 4), 32'h0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ots_issue%0d got=blocked exp=accepted", i); end
    end
    @(negedge clk);
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b0; icb_cmd_addr = 32'h410;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({icb_cmd_rdy, axi_arvalid} !== 2'b00) begin errors++;
        $display("FAIL ots_full_c%0d got=%b exp=00", c, {icb_cmd_rdy, axi_arvalid}); end
      @(negedge clk);
    end
    axi_rvalid = 1'b1; axi_rdata = 32'h11; axi_rresp = 2'b00;
    #1;
    checks++; if ({axi_rready, icb_cmd_rdy} !== 2'b10) begin errors++;
      $display("FAIL ots_pop_blocks got=%b exp=10", {axi_rready, icb_cmd_rdy}); end
    @(negedge clk);
    axi_rvalid = 1'b0;
    #1;
    checks++; if (icb_cmd_rdy !== 1'b1) begin errors++; $display("FAIL ots_after_pop got=%b exp=1", icb_cmd_rdy); end
    @(negedge clk);
    icb_cmd_vld = 1'b0; axi_arready = 1'b0;
    checks++; if (ar_cnt - base !== 5) begin errors++; $display("FAIL ots_ar_count got=%0d exp=5", ar_cnt - base); end
    exp_d[0] = 32'h11;
    for (int i = 0; i < 4; i++) begin
      exp_d[i+1] = 32'h20 + 32'(i);
      send_r(exp_d[i+1], 2'b00, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ots_r%0d got=none exp=handshake", i); end
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(got, v);
      checks++; if (!got || v !== {1'b0, exp_d[i]}) begin errors++;
        $display("FAIL ots_rsp%0d got=%0b/%h exp=0/%h", i, got, v, exp_d[i]); end
    end
  endtask

  task automatic test_order();
    bit ok, got;
    logic [32:0] v;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1; icb_rsp_rdy = 1'b1;
    issue(1'b1, 32'h300, 32'hAAAA5555, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ord_issue_wr got=blocked exp=accepted"); end
    issue(1'b0, 32'h304, 32'h0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ord_issue_rd got=blocked exp=accepted"); end
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'hCAFEF00D; axi_rresp = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (axi_rready !== 1'b0) begin errors++; $display("FAIL ord_rready_early_c%0d got=%b exp=0", c, axi_rready); end
      @(negedge clk);
    end
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    #1;
    checks++; if ({axi_bready, axi_rready} !== 2'b10) begin errors++;
      $display("FAIL ord_b_first got=%b exp=10", {axi_bready, axi_rready}); end
    @(negedge clk);
    axi_bvalid = 1'b0;
    #1;
    checks++; if (axi_rready !== 1'b1) begin errors++; $display("FAIL ord_r_second got=%b exp=1", axi_rready); end
    @(negedge clk);
    axi_rvalid = 1'b0;
    get_rsp(got, v);
    checks++; if (!got || v !== 33'd0) begin errors++; $display("FAIL ord_rsp_wr got=%0b/%h exp=0/0", got, v); end
    get_rsp(got, v);
    checks++; if (!got || v !== {1'b0, 32'hCAFEF00D}) begin errors++;
      $display("FAIL ord_rsp_rd got=%0b/%h exp=0/cafef00d", got, v); end
  endtask

  task automatic test_bresp_err();
    bit ok, got;
    logic [32:0] v;
    logic [1:0] tbl[4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1; icb_rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h600, 32'h1, ok);
      send_b(tbl[i], ok);
      get_rsp(got, v);
      checks++; if (!got || v !== {tbl[i][1], 32'h0}) begin errors++;
        $display("FAIL berr_%0d got=%0b/%h exp=%b/0", i, got, v, tbl[i][1]); end
    end
    issue(1'b0, 32'h604, 32'h0, ok);
    send_r(32'h5A5A0001, 2'b10, ok);
    get_rsp(got, v);
    checks++; if (!got || v !== {1'b1, 32'h5A5A0001}) begin errors++;
      $display("FAIL rerr got=%0b/%h exp=1/5a5a0001", got, v); end
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
  endtask

  task automatic test_random();
    logic [33:0] exp_q[$];
    logic [1:0]  b_pend[$];
    logic [33:0] r_pend[$];
    bit          ord_q[$];
    int outst = 0;
    bit cmd_act = 0, cmd_wr = 0, aw_seen = 0, w_seen = 0, b_hs = 0, r_hs = 0, gen;
    bit exp_ar, exp_aw, exp_w, exp_rdy;
    logic [31:0] cmd_addr = '0, cmd_data = '0, rd;
    logic [3:0]  cmd_strb = '0;
    logic [1:0]  rr;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gen = (cyc < 800);
      if (!gen && !cmd_act && exp_q.size() == 0) break;
      @(negedge clk);
      if (b_hs) axi_bvalid = 1'b0;
      if (r_hs) axi_rvalid = 1'b0;
      if (!cmd_act && gen && $urandom_range(0, 2) != 0) begin
        cmd_act = 1; cmd_wr = 1'($urandom); cmd_addr = $urandom & 32'hFFFF_FFFC;
        cmd_data = $urandom; cmd_strb = 4'($urandom); aw_seen = 0; w_seen = 0;
      end
      icb_cmd_vld = cmd_act; icb_cmd_write = cmd_wr; icb_cmd_addr = cmd_addr;
      icb_cmd_wdata = cmd_data; icb_cmd_wstrb = cmd_strb; icb_cmd_size = 3'd2;
      axi_awready = 1'($urandom); axi_wready = 1'($urandom); axi_arready = 1'($urandom);
      icb_rsp_rdy = ($urandom_range(0, 3) != 0);
      if (!axi_bvalid && b_pend.size() > 0 && 1'($urandom)) begin axi_bvalid = 1'b1; axi_bresp = b_pend[0]; end
      if (!axi_rvalid && r_pend.size() > 0 && 1'($urandom)) begin axi_rvalid = 1'b1; {axi_rresp, axi_rdata} = r_pend[0]; end
      #1;
      exp_ar  = cmd_act && !cmd_wr && outst < OTS;
      exp_aw  = cmd_act && cmd_wr && outst < OTS && !aw_seen;
      exp_w   = cmd_act && cmd_wr && outst < OTS && !w_seen;
      exp_rdy = exp_ar ? axi_arready
              : (cmd_act && cmd_wr && outst < OTS && (aw_seen || axi_awready) && (w_seen || axi_wready));
      checks++; if ({axi_arvalid, axi_awvalid, axi_wvalid} !== {exp_ar, exp_aw, exp_w}) begin errors++;
        $display("FAIL rnd_valids cyc=%0d got=%b exp=%b", cyc, {axi_arvalid, axi_awvalid, axi_wvalid}, {exp_ar, exp_aw, exp_w}); end
      checks++; if (icb_cmd_rdy !== exp_rdy) begin errors++;
        $display("FAIL rnd_cmd_rdy cyc=%0d got=%b exp=%b outst=%0d", cyc, icb_cmd_rdy, exp_rdy, outst); end
      if (axi_arvalid && axi_arready) begin
        checks++; if (axi_araddr !== cmd_addr) begin errors++; $display("FAIL rnd_araddr got=%h exp=%h", axi_araddr, cmd_addr); end
      end
      if (axi_awvalid && axi_awready) begin
        checks++; if (axi_awaddr !== cmd_addr) begin errors++; $display("FAIL rnd_awaddr got=%h exp=%h", axi_awaddr, cmd_addr); end
      end
      if (axi_wvalid && axi_wready) begin
        checks++; if ({axi_wdata, axi_wstrb, axi_wlast} !== {cmd_data, cmd_strb, 1'b1}) begin errors++;
          $display("FAIL rnd_wbeat got=%h/%h/%b exp=%h/%h/1", axi_wdata, axi_wstrb, axi_wlast, cmd_data, cmd_strb); end
      end
      if (axi_bready) begin
        checks++; if (!(ord_q.size() > 0 && ord_q[0] == 1'b1)) begin errors++;
          $display("FAIL rnd_bready_order cyc=%0d got=1 exp=0", cyc); end
      end
      if (axi_rready) begin
        checks++; if (!(ord_q.size() > 0 && ord_q[0] == 1'b0)) begin errors++;
          $display("FAIL rnd_rready_order cyc=%0d got=1 exp=0", cyc); end
      end
      if (icb_rsp_vld && icb_rsp_rdy) begin
        checks++; if (!(exp_q.size() > 0 && {icb_rsp_err, icb_rsp_rdata} === exp_q[0][32:0])) begin errors++;
          $display("FAIL rnd_rsp cyc=%0d got=%b/%h exp=%h", cyc, icb_rsp_err, icb_rsp_rdata, (exp_q.size() > 0) ? exp_q[0] : 34'h0); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      b_hs = axi_bvalid && axi_bready;
      r_hs = axi_rvalid && axi_rready;
      if (b_hs) begin void'(b_pend.pop_front()); if (ord_q.size() > 0) void'(ord_q.pop_front()); outst--; end
      if (r_hs) begin void'(r_pend.pop_front()); if (ord_q.size() > 0) void'(ord_q.pop_front()); outst--; end
      if (icb_cmd_vld && icb_cmd_rdy) begin
        if (cmd_wr) begin
          rr = 2'($urandom); b_pend.push_back(rr); exp_q.push_back({1'b1, rr[1], 32'h0});
        end else begin
          rd = $urandom; rr = 2'($urandom); r_pend.push_back({rr, rd}); exp_q.push_back({1'b0, rr[1], rd});
        end
        ord_q.push_back(cmd_wr); outst++; cmd_act = 0;
      end else begin
        if (axi_awvalid && axi_awready) aw_seen = 1;
        if (axi_wvalid && axi_wready) w_seen = 1;
      end
    end
    checks++; if (exp_q.size() != 0 || outst != 0) begin errors++;
      $display("FAIL rnd_drain got=%0d/%0d exp=0/0", exp_q.size(), outst); end
    @(negedge clk);
    icb_cmd_vld = 1'b0; axi_bvalid = 1'b0; axi_rvalid = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0; icb_rsp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rsp_rd = rsp_log.size();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int snap;
    axi_arready = 1'b1; icb_rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h500 + 32'(i * 4), 32'h0, ok);
    reset_n = 1'b0; axi_rvalid = 1'b1; axi_bvalid = 1'b1; axi_rdata = 32'h55; axi_bresp = 2'b00;
    #1;
    checks++; if ({axi_rready, axi_bready} !== 2'b00) begin errors++;
      $display("FAIL rmid_in_reset got=%b exp=00", {axi_rready, axi_bready}); end
    snap = rsp_log.size();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if ({axi_rready, axi_bready, icb_rsp_vld} !== 3'b000) begin errors++;
      $display("FAIL rmid_after got=%b exp=000", {axi_rready, axi_bready, icb_rsp_vld}); end
    @(negedge clk);
    axi_rvalid = 1'b0; axi_bvalid = 1'b0;
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b0; icb_cmd_addr = 32'h700;
    #1;
    checks++; if (icb_cmd_rdy !== 1'b1) begin errors++; $display("FAIL rmid_new_rd got=%b exp=1", icb_cmd_rdy); end
    @(negedge clk);
    icb_cmd_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 32'h704 + 32'(i * 4), 32'h0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_fill%0d got=blocked exp=accepted", i); end
    end
    icb_cmd_vld = 1'b1;
    #1;
    checks++; if (icb_cmd_rdy !== 1'b0) begin errors++; $display("FAIL rmid_full got=%b exp=0", icb_cmd_rdy); end
    @(negedge clk);
    icb_cmd_vld = 1'b0; axi_arready = 1'b0;
    checks++; if (rsp_log.size() != snap) begin errors++;
      $display("FAIL rmid_no_rsp got=%0d exp=%0d", rsp_log.size(), snap); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    icb_cmd_vld = 1'b0; icb_cmd_write = 1'b0; icb_cmd_addr = '0; icb_cmd_wdata = '0;
    icb_cmd_wstrb = '0; icb_cmd_size = 3'd2; icb_rsp_rdy = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
    axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = 4'd0;
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b1; axi_rid = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_write_aw_stall();
    test_ots_full();
    test_order();
    test_bresp_err();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lnrv_icb2axi_mots.md
LNRV_ICB2AXI_MOTS -- requirements
Module: lnrv_icb2axi_mots

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 32, address width of ICB and AXI.
REQ-002 SHALL have parameter P_DATA_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter P_OTS_COUNT, default 4, maximum outstanding transactions; legal values are powers of 2 from 1 to 16.
REQ-004 SHALL have parameter P_AXI_ID, default 4'd0, value driven on axi_awid and axi_arid.
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-low (clk, reset_n as in the codebase).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 icb_cmd_vld/icb_cmd_write  in  1 each; icb_cmd_rdy  out  1; ICB command handshake and direction.
REQ-009 icb_cmd_addr  in  P_ADDR_WIDTH; icb_cmd_wdata  in  P_DATA_WIDTH; icb_cmd_wstrb  in  P_DATA_WIDTH/8; icb_cmd_size  in  3.
REQ-010 icb_rsp_vld/icb_rsp_err  out  1 each; icb_rsp_rdy  in  1; icb_rsp_rdata  out  P_DATA_WIDTH.
REQ-011 AXI AW: axi_awvalid out 1, axi_awready in 1, axi_awaddr out P_ADDR_WIDTH, axi_awid out 4, axi_awlen out 8, axi_awsize out 3, axi_awburst out 2, axi_awcache out 4, axi_awprot out 3, axi_awlock out 1.
REQ-012 AXI W: axi_wvalid out 1, axi_wready in 1, axi_wdata out P_DATA_WIDTH, axi_wstrb out P_DATA_WIDTH/8, axi_wlast out 1.
REQ-013 AXI B: axi_bvalid in 1, axi_bready out 1, axi_bresp in 2, axi_bid in 4.
REQ-014 AXI AR: same set as AW with ar prefix; AXI R: axi_rvalid in 1, axi_rready out 1, axi_rdata in P_DATA_WIDTH, axi_rresp in 2, axi_rlast in 1, axi_rid in 4.

Function
REQ-015 Constants: awlen/arlen = 0, awburst/arburst = 2'b01, cache = 0, prot = 0, lock = 0, wlast = 1 whenever wvalid is 1, awsize/arsize = icb_cmd_size, addr/wdata/wstrb passed through combinationally.
REQ-016 Ordering FIFO, depth P_OTS_COUNT, SHALL hold one type bit (1 = write) per issued transaction; an occupancy counter of log2(P_OTS_COUNT)+1 bits SHALL track it.
REQ-017 Read: axi_arvalid = icb_cmd_vld & ~icb_cmd_write & ~full; ICB command accepted on the AR handshake, pushing type 0.
REQ-018 Write: AW and W SHALL be independent; flags aw_done/w_done record a completed handshake; axi_awvalid = vld & write & ~full & ~aw_done, axi_wvalid likewise with ~w_done.
REQ-019 Write command is accepted (icb_cmd_rdy = 1, push type 1, both flags cleared) in the cycle in which both channels are done or completing.
REQ-020 icb_cmd_rdy = 0 when full; full with a simultaneous pop SHALL still block (no same-cycle push/pop bypass when full).
REQ-021 Responses SHALL return in issue order: axi_rready = head valid & head type 0 & rsp-path ready; axi_bready = head valid & head type 1 & rsp-path ready; a B arriving while the head is a read waits, and vice versa.
REQ-022 icb_rsp_err = resp[1] of the accepted channel (SLVERR/DECERR); icb_rsp_rdata = axi_rdata on reads, 0 on writes.
REQ-023 Simultaneous push and pop when not full SHALL leave occupancy unchanged; pointers wrap modulo P_OTS_COUNT.
REQ-024 Command-to-AXI-valid latency SHALL be 0 cycles.

Reset
REQ-025 On reset_n low: FIFO empty, counter 0, aw_done = w_done = 0; all valid outputs and icb_cmd_rdy 0 while reset_n is low.
REQ-026 Reset mid-transaction SHALL discard all outstanding state; late B/R beats after reset are never forwarded while the FIFO is empty (bready = rready = 0).

Configuration
REQ-027 With LNRV_ICB2AXI_RSP_BUF_EN defined, a one-entry response register (data, err) SHALL sit between AXI B/R and the ICB response; rsp-path ready = buffer empty or icb_rsp_rdy, adding 1 cycle of latency.
REQ-028 Without LNRV_ICB2AXI_RSP_BUF_EN, icb_rsp_vld/err/rdata SHALL be combinational from the head-selected channel, and rsp-path ready = icb_rsp_rdy.

Verification
REQ-029 Single read to 0x100, rdata 0xDEADBEEF, rresp 0 -> one AR with araddr 0x100, arlen 0; icb_rsp_rdata 0xDEADBEEF, err 0.
REQ-030 Write with awready held 0 for 3 cycles and wready 1 -> W handshake on cycle 0, wvalid drops, AW on cycle 3, icb_cmd_rdy pulses in cycle 3 only.
REQ-031 P_OTS_COUNT 4, five back-to-back reads, no R returned -> four ARs issued, icb_cmd_rdy 0 on the fifth until the first R handshake.
REQ-032 Issue write then read; slave returns R before B -> rready held 0 until B accepted; ICB responses in order write, read.
REQ-033 bresp 2'b10 -> icb_rsp_err 1; bresp 2'b01 -> icb_rsp_err 0.
REQ-034 reset_n pulsed low with 3 outstanding -> after release counter 0, icb_cmd_rdy follows a new read immediately, bready/rready 0.
